// File: rtl/alu_share_if.sv
// Requester, ALU and response buses for alu_share_arbiter.
// The master modport is the environment side; slave is the arbiter.
interface alu_share_if #(
    parameter int WIDTH  = 32,
    parameter int OP_W   = 4,
    parameter int FLAG_W = 4
);
    logic              req0_valid;
    logic              req0_ready;
    logic [WIDTH-1:0]  req0_a;
    logic [WIDTH-1:0]  req0_b;
    logic [OP_W-1:0]   req0_op;
    logic              req1_valid;
    logic              req1_ready;
    logic [WIDTH-1:0]  req1_a;
    logic [WIDTH-1:0]  req1_b;
    logic [OP_W-1:0]   req1_op;
    logic [WIDTH-1:0]  alu_a;
    logic [WIDTH-1:0]  alu_b;
    logic [OP_W-1:0]   alu_op;
    logic [WIDTH-1:0]  alu_f;
    logic [FLAG_W-1:0] alu_flag;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WIDTH-1:0]  rsp_f;
    logic [FLAG_W-1:0] rsp_flag;
    logic              rsp_id;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_op,
        output alu_f, alu_flag,
        input  rsp_valid, rsp_f, rsp_flag, rsp_id,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_op,
        input  alu_f, alu_flag,
        output rsp_valid, rsp_f, rsp_flag, rsp_id,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters with a tagged valid/ready response.
// ALU_SHARE_RR_EN selects round-robin tie breaking; default is fixed priority to requester 0.
//
// state | meaning
// IDLE  | waiting for a request; grants and latches the winner's operands
// ISSUE | ALU settles on registered operands; result captured at the closing edge
// RESP  | response held until the consumer takes it
module alu_share_arbiter #(
    parameter int WIDTH  = 32,
    parameter int OP_W   = 4,
    parameter int FLAG_W = 4
) (
    input  logic        clk_10M,
    input  logic        reset_of_clk10M,
    alu_share_if.slave  bus,
    output logic        busy,
    output logic [15:0] op_count
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    logic [1:0]        state;
    logic              last_grant;
    logic              grant_vld;
    logic              grant_id;
    logic [WIDTH-1:0]  alu_a_r;
    logic [WIDTH-1:0]  alu_b_r;
    logic [OP_W-1:0]   alu_op_r;
    logic [WIDTH-1:0]  rsp_f_r;
    logic [FLAG_W-1:0] rsp_flag_r;
    logic              rsp_valid_r;
    logic              rsp_id_r;
    logic [15:0]       op_count_r;

    always_comb begin
        grant_vld = bus.req0_valid | bus.req1_valid;
        grant_id  = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
`ifdef ALU_SHARE_RR_EN
            grant_id = ~last_grant;
`else
            grant_id = 1'b0;
`endif
        end else if (bus.req1_valid) begin
            grant_id = 1'b1;
        end
    end

`ifndef ALU_SHARE_RR_EN
    // last_grant is still tracked so both builds share one register set.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    assign bus.req0_ready = (state == IDLE) && grant_vld && !grant_id;
    assign bus.req1_ready = (state == IDLE) && grant_vld &&  grant_id;

    always_ff @(posedge clk_10M or posedge reset_of_clk10M) begin
        if (reset_of_clk10M) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            alu_a_r     <= '0;
            alu_b_r     <= '0;
            alu_op_r    <= '0;
            rsp_f_r     <= '0;
            rsp_flag_r  <= '0;
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= 1'b0;
            op_count_r  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        alu_a_r  <= grant_id ? bus.req1_a  : bus.req0_a;
                        alu_b_r  <= grant_id ? bus.req1_b  : bus.req0_b;
                        alu_op_r <= grant_id ? bus.req1_op : bus.req0_op;
                        rsp_id_r <= grant_id;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    rsp_f_r     <= bus.alu_f;
                    rsp_flag_r  <= bus.alu_flag;
                    rsp_valid_r <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (rsp_valid_r && bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        last_grant  <= rsp_id_r;
                        op_count_r  <= op_count_r + 16'd1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.alu_a     = alu_a_r;
    assign bus.alu_b     = alu_b_r;
    assign bus.alu_op    = alu_op_r;
    assign bus.rsp_f     = rsp_f_r;
    assign bus.rsp_flag  = rsp_flag_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_id    = rsp_id_r;
    assign busy          = (state != IDLE);
    assign op_count      = op_count_r;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios plus a randomized run
// against a transaction-level model (one op in flight, response one edge after issue).
`timescale 1ns/1ps
module tb_alu_share_arbiter;
    localparam int WIDTH  = 32;
    localparam int OP_W   = 4;
    localparam int FLAG_W = 4;

    logic        clk_10M = 1'b0;
    logic        reset_of_clk10M = 1'b1;
    logic        busy;
    logic [15:0] op_count;
    int          n_checks = 0;
    int          n_fail = 0;

    alu_share_if #(.WIDTH(WIDTH), .OP_W(OP_W), .FLAG_W(FLAG_W)) bus ();

    alu_share_arbiter #(.WIDTH(WIDTH), .OP_W(OP_W), .FLAG_W(FLAG_W)) dut (
        .clk_10M         (clk_10M),
        .reset_of_clk10M (reset_of_clk10M),
        .bus             (bus),
        .busy            (busy),
        .op_count        (op_count)
    );

    always #50 clk_10M = ~clk_10M;

    function automatic logic [WIDTH-1:0] alu_fn(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b,
                                                logic [OP_W-1:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    function automatic logic [FLAG_W-1:0] alu_flags(logic [WIDTH-1:0] f);
        return {2'b00, f[WIDTH-1], (f == '0)};
    endfunction

    // Stand-in ALU driven from the arbiter's registered operands.
    always_comb begin
        logic [WIDTH-1:0] f;
        f = alu_fn(bus.alu_a, bus.alu_b, bus.alu_op);
        bus.alu_f    = f;
        bus.alu_flag = alu_flags(f);
    end

    task automatic tick();
        @(posedge clk_10M);
        #1;
    endtask

    task automatic do_reset();
        reset_of_clk10M = 1'b1;
        bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req0_op = 0;
        bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0; bus.req1_op = 0;
        bus.rsp_ready = 0;
        tick();
        tick();
        reset_of_clk10M = 1'b0;
        #1;
    endtask

    task automatic run_one_req0(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, logic [OP_W-1:0] op);
        bit done;
        bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
        bus.req0_valid = 1; bus.rsp_ready = 1;
        done = 0;
        for (int c = 0; c < 10 && !done; c++) begin
            #1;
            done = bus.req0_ready;
            tick();
        end
        bus.req0_valid = 0;
        done = 0;
        for (int c = 0; c < 10 && !done; c++) begin
            done = bus.rsp_valid;
            tick();
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL run_one_timeout: no response within bound");
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        n_checks++; if (op_count !== 16'd0) begin n_fail++; $display("FAIL reset_op_count: got %0h want 0", op_count); end
        n_checks++; if ({bus.alu_a, bus.alu_b, bus.alu_op} !== '0) begin n_fail++; $display("FAIL reset_alu_regs: got %0h want 0", {bus.alu_a, bus.alu_b, bus.alu_op}); end
        n_checks++; if ({bus.rsp_f, bus.rsp_flag, bus.rsp_id} !== '0) begin n_fail++; $display("FAIL reset_rsp_regs: got %0h want 0", {bus.rsp_f, bus.rsp_flag, bus.rsp_id}); end
    endtask

    task automatic test_single();
        do_reset();
        bus.rsp_ready = 1;
        bus.req0_a = 5; bus.req0_b = 3; bus.req0_op = 0; bus.req0_valid = 1;
        #1;
        n_checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin n_fail++; $display("FAIL single_ready: got %b want 10", {bus.req0_ready, bus.req1_ready}); end
        tick();
        n_checks++; if (bus.req0_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready_one_cycle: got %b want 0", bus.req0_ready); end
        n_checks++; if (bus.alu_a !== 32'd5 || bus.alu_b !== 32'd3) begin n_fail++; $display("FAIL single_alu_ops: got %0d,%0d want 5,3", bus.alu_a, bus.alu_b); end
        n_checks++; if (bus.rsp_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL single_issue: rsp_valid %b busy %b want 0 1", bus.rsp_valid, busy); end
        tick();
        n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency: rsp_valid %b want 1", bus.rsp_valid); end
        n_checks++; if (bus.rsp_f !== 32'd8 || bus.rsp_id !== 1'b0) begin n_fail++; $display("FAIL single_result: got f=%0d id=%b want 8 0", bus.rsp_f, bus.rsp_id); end
        bus.req0_valid = 0;
        tick();
        n_checks++; if (op_count !== 16'd1 || bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_done: cnt=%0d rv=%b busy=%b want 1 0 0", op_count, bus.rsp_valid, busy); end
    endtask

    task automatic test_hold();
        bus.rsp_ready = 0;
        bus.req1_a = 7; bus.req1_b = 7; bus.req1_op = 1; bus.req1_valid = 1;
        #1;
        n_checks++; if (bus.req1_ready !== 1'b1) begin n_fail++; $display("FAIL hold_req1_ready: got %b want 1", bus.req1_ready); end
        tick();
        bus.req1_valid = 0;
        bus.req0_a = 1; bus.req0_b = 1; bus.req0_op = 0; bus.req0_valid = 1;
        tick();
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_f !== 32'd0 || bus.rsp_flag[0] !== 1'b1 || bus.rsp_id !== 1'b1) begin
                n_fail++; $display("FAIL hold_stable[%0d]: rv=%b f=%0h z=%b id=%b want 1 0 1 1", i, bus.rsp_valid, bus.rsp_f, bus.rsp_flag[0], bus.rsp_id);
            end
            n_checks++; if (bus.req0_ready !== 1'b0) begin n_fail++; $display("FAIL hold_req0_blocked[%0d]: got %b want 0", i, bus.req0_ready); end
            tick();
        end
        bus.rsp_ready = 1;
        tick();
        n_checks++; if (op_count !== 16'd2 || bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL hold_done: cnt=%0d rv=%b want 2 0", op_count, bus.rsp_valid); end
        n_checks++; if (bus.req0_ready !== 1'b1) begin n_fail++; $display("FAIL hold_waiting_accept: got %b want 1", bus.req0_ready); end
        bus.req0_valid = 0;
        #1;
        tick();
        tick();
        n_checks++; if (busy !== 1'b0 || op_count !== 16'd2) begin n_fail++; $display("FAIL hold_drop_and_idle_ready: busy=%b cnt=%0d want 0 2", busy, op_count); end
    endtask

    task automatic test_tie();
        logic ids [4];
        int   n = 0;
        do_reset();
        bus.rsp_ready = 1;
        bus.req0_a = 10; bus.req0_b = 1; bus.req0_op = 0; bus.req0_valid = 1;
        bus.req1_a = 20; bus.req1_b = 2; bus.req1_op = 1; bus.req1_valid = 1;
        for (int c = 0; c < 40 && n < 4; c++) begin
            if (bus.rsp_valid === 1'b1) begin ids[n] = bus.rsp_id; n++; end
            tick();
        end
        bus.req0_valid = 0; bus.req1_valid = 0;
        n_checks++; if (n != 4) begin n_fail++; $display("FAIL tie_count: got %0d responses want 4", n); end
        for (int i = 0; i < n; i++) begin
            logic exp_id;
`ifdef ALU_SHARE_RR_EN
            exp_id = (i % 2 == 1);
`else
            exp_id = 1'b0;
`endif
            n_checks++; if (ids[i] !== exp_id) begin n_fail++; $display("FAIL tie_id[%0d]: got %b want %b", i, ids[i], exp_id); end
        end
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.req0_a = 9; bus.req0_b = 4; bus.req0_op = 1; bus.req0_valid = 1; bus.rsp_ready = 1;
        #1;
        tick();
        bus.req0_valid = 0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_in_issue: busy %b want 1", busy); end
        reset_of_clk10M = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_async: busy=%b rv=%b want 0 0", busy, bus.rsp_valid); end
        tick();
        reset_of_clk10M = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (bus.rsp_valid !== 1'b0 || busy !== 1'b0 || op_count !== 16'd0) begin n_fail++; $display("FAIL midrst_after[%0d]: rv=%b busy=%b cnt=%0d want 0 0 0", i, bus.rsp_valid, busy, op_count); end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        force dut.op_count_r = 16'hFFFE;
        tick();
        release dut.op_count_r;
        #1;
        n_checks++; if (op_count !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_preload: got %0h want fffe", op_count); end
        run_one_req0(32'd1, 32'd2, 4'd0);
        n_checks++; if (op_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_ffff: got %0h want ffff", op_count); end
        run_one_req0(32'd3, 32'd4, 4'd0);
        n_checks++; if (op_count !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero: got %0h want 0", op_count); end
    endtask

    task automatic test_back_to_back();
        int            accepts = 0;
        int            last_acc = -1;
        logic [OP_W-1:0] prev_op;
        do_reset();
        bus.rsp_ready = 1;
        bus.req0_a = 32'h100; bus.req0_b = 32'h1; bus.req0_op = 4'd1; bus.req0_valid = 1;
        #1;
        for (int c = 0; c < 30 && accepts < 5; c++) begin
            bit acc;
            acc = bus.req0_ready;
            prev_op = bus.alu_op;
            tick();
            if (acc) begin
                n_checks++; if (bus.alu_op !== bus.req0_op) begin n_fail++; $display("FAIL b2b_op_load[%0d]: got %0d want %0d", accepts, bus.alu_op, bus.req0_op); end
                if (last_acc >= 0) begin
                    n_checks++; if (c - last_acc != 3) begin n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d cycles want 3", accepts, c - last_acc); end
                end
                last_acc = c;
                accepts++;
                bus.req0_op = 4'((accepts % 4) + 1);
                bus.req0_a  = bus.req0_a + 32'd17;
                #1;
            end else begin
                n_checks++; if (bus.alu_op !== prev_op) begin n_fail++; $display("FAIL b2b_op_hold[%0d]: got %0d want %0d", c, bus.alu_op, prev_op); end
            end
        end
        bus.req0_valid = 0;
        n_checks++; if (accepts != 5) begin n_fail++; $display("FAIL b2b_accepts: got %0d want 5", accepts); end
        tick();
        tick();
    endtask

    task automatic test_random();
        bit              m_busy = 0;
        int              m_age = 0;
        logic            m_id = 0;
        logic [WIDTH-1:0] m_f = 0;
        logic            m_last = 1;
        logic [15:0]     m_count = 0;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            bit   v0, v1, acc, hs, exp_rv;
            logic g;
            v0 = ($urandom_range(0, 2) != 0);
            v1 = ($urandom_range(0, 2) != 0);
            bus.req0_valid = v0; bus.req0_a = $urandom; bus.req0_b = $urandom; bus.req0_op = 4'($urandom_range(0, 5));
            bus.req1_valid = v1; bus.req1_a = $urandom; bus.req1_b = $urandom; bus.req1_op = 4'($urandom_range(0, 5));
            bus.rsp_ready = ($urandom_range(0, 1) == 1);
            #1;
            acc = !m_busy && (v0 || v1);
`ifdef ALU_SHARE_RR_EN
            g = (v0 && v1) ? !m_last : v1;
`else
            g = (v0 && v1) ? 1'b0 : v1;
`endif
            n_checks++;
            if (bus.req0_ready !== (acc && !g) || bus.req1_ready !== (acc && g)) begin
                n_fail++; $display("FAIL rnd_ready[%0d]: got %b%b want %b%b", c, bus.req1_ready, bus.req0_ready, acc && g, acc && !g);
            end
            exp_rv = m_busy && (m_age >= 1);
            n_checks++;
            if (bus.rsp_valid !== exp_rv || busy !== m_busy || op_count !== m_count) begin
                n_fail++; $display("FAIL rnd_status[%0d]: rv=%b busy=%b cnt=%0d want %b %b %0d", c, bus.rsp_valid, busy, op_count, exp_rv, m_busy, m_count);
            end
            if (exp_rv) begin
                n_checks++;
                if (bus.rsp_f !== m_f || bus.rsp_id !== m_id || bus.rsp_flag !== alu_flags(m_f)) begin
                    n_fail++; $display("FAIL rnd_rsp[%0d]: f=%0h id=%b flag=%0h want %0h %b %0h", c, bus.rsp_f, bus.rsp_id, bus.rsp_flag, m_f, m_id, alu_flags(m_f));
                end
            end
            hs = exp_rv && bus.rsp_ready;
            if (acc) begin
                m_id = g;
                m_f  = g ? alu_fn(bus.req1_a, bus.req1_b, bus.req1_op) : alu_fn(bus.req0_a, bus.req0_b, bus.req0_op);
            end
            tick();
            if (m_busy) m_age++;
            if (hs) begin
                m_busy = 0; m_last = m_id; m_count++;
            end
            if (acc) begin
                m_busy = 1; m_age = 0;
            end
        end
        bus.req0_valid = 0; bus.req1_valid = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_hold();
        test_tie();
        test_reset_mid();
        test_wrap();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
